// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pkg: shared FSM state type and requester IDs for the     |
// | CPU/DMA memory arbiter.            Revision: 1.0                 |
// +------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int CNT_W = 3;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pick: winner selection and last-grant (owner) register.  |
// | Macro MEM_ARB_RR_EN: round-robin ties, else CPU wins ties.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic grant,
  output logic winner,
  output logic owner
);

  logic r_last;
  logic w_tie;

  assign w_tie = cpu_req & dma_req;

`ifdef MEM_ARB_RR_EN
  assign winner = w_tie ? ~r_last : (cpu_req ? REQ_CPU : REQ_DMA);
`else
  assign winner = (w_tie | cpu_req) ? REQ_CPU : REQ_DMA;
`endif

  // The last grantee is also the owner of the transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= REQ_DMA;
    end else if (grant) begin
      r_last <= winner;
    end
  end

  assign owner = r_last;

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter: CPU/DMA arbiter in front of a single-port memory    |
// | with LAT-cycle read latency. Option macro: MEM_ARB_RR_EN.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [CNT_W-1:0] c_LAT_M1 = CNT_W'(LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic             w_grant;
  logic             w_winner;
  logic             w_owner;
  logic             w_rd_done;

  assign w_grant   = (r_state == IDLE) & (cpu_req | dma_req);
  assign w_rd_done = (r_state == WAIT) & (r_cnt == c_LAT_M1);

  mem_arb_pick u_pick (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .grant   (w_grant),
    .winner  (w_winner),
    .owner   (w_owner)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cpu_req | dma_req) w_next = ACCESS;
      ACCESS:  w_next = r_we ? DONE : WAIT;
      WAIT:    if (w_rd_done) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    cpu_ack = 1'b0;
    dma_ack = 1'b0;
    case (r_state)
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = r_we;
      end
      DONE: begin
        cpu_ack = (w_owner == REQ_CPU);
        dma_ack = (w_owner == REQ_DMA);
      end
      default: ;
    endcase
  end

  // Request payload is latched at grant and held on the memory bus until the next grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we      <= 1'b0;
      r_cnt     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_we      <= (w_winner == REQ_DMA) ? dma_we    : cpu_we;
        mem_addr  <= (w_winner == REQ_DMA) ? dma_addr  : cpu_addr;
        mem_wdata <= (w_winner == REQ_DMA) ? dma_wdata : cpu_wdata;
      end
      if (r_state == ACCESS) begin
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_rd_done) begin
        if (w_owner == REQ_CPU) begin
          cpu_rdata <= mem_rdata;
        end else begin
          dma_rdata <= mem_rdata;
        end
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (r_state != IDLE);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter: scoreboard bench for mem_arbiter (LAT 2, 1, 7).  |
// | Tie model follows MEM_ARB_RR_EN.   Revision: 1.0                 |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int LAT = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_ack, cpu_stall, dma_ack, mem_en, mem_we, busy;

  // Latency-only instances: index 0 has LAT=1, index 1 has LAT=7.
  logic [1:0]  l_req = 2'b00;
  logic [31:0] l_addr = '0;
  logic [31:0] l_mrdata [2];
  logic [31:0] l_rdata [2], l_drdata [2], l_maddr [2], l_mwdata [2];
  logic [1:0]  l_ack, l_stall, l_dack, l_en, l_we, l_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mem_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.AW(32), .DW(32), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .cpu_req(l_req[0]), .cpu_we(1'b0), .cpu_addr(l_addr), .cpu_wdata(32'h0),
    .cpu_rdata(l_rdata[0]), .cpu_ack(l_ack[0]), .cpu_stall(l_stall[0]),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_rdata(l_drdata[0]), .dma_ack(l_dack[0]),
    .mem_en(l_en[0]), .mem_we(l_we[0]), .mem_addr(l_maddr[0]), .mem_wdata(l_mwdata[0]),
    .mem_rdata(l_mrdata[0]), .busy(l_busy[0])
  );

  mem_arbiter #(.AW(32), .DW(32), .LAT(7)) u_lat7 (
    .clk(clk), .rst(rst),
    .cpu_req(l_req[1]), .cpu_we(1'b0), .cpu_addr(l_addr), .cpu_wdata(32'h0),
    .cpu_rdata(l_rdata[1]), .cpu_ack(l_ack[1]), .cpu_stall(l_stall[1]),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_rdata(l_drdata[1]), .dma_ack(l_dack[1]),
    .mem_en(l_en[1]), .mem_we(l_we[1]), .mem_addr(l_maddr[1]), .mem_wdata(l_mwdata[1]),
    .mem_rdata(l_mrdata[1]), .busy(l_busy[1])
  );

  // Environment memory and the requesters' own view of it.
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard state
  txn_t cq[$], dq[$];
  int   lats [3] = '{LAT, 1, 7};
  logic hen  [3][8];
  logic [31:0] haddr [3][8];
  int   g_cyc = -100, ack_cyc = -100;
  logic g_who = 1'b0, g_we = 1'b0, last = 1'b1;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [31:0] e_rdata [2] = '{32'h0, 32'h0};
  bit   granted [2] = '{0, 0};
  bit   ack_seen [2] = '{0, 0};
  int   ack_at [2] = '{0, 0};

  initial begin
    for (int d = 0; d < 3; d++)
      for (int j = 0; j < 8; j++) begin
        hen[d][j] = 1'b0;
        haddr[d][j] = '0;
      end
    l_mrdata[0] = '0;
    l_mrdata[1] = '0;
  end

  // Memory: read data of a strobe at cycle c is valid only in cycle c+LAT.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int d = 0; d < 3; d++) begin
        logic [31:0] v;
        v = $urandom;
        if (cyc >= lats[d] && hen[d][(cyc - lats[d]) % 8]) v = mem_rd(haddr[d][(cyc - lats[d]) % 8]);
        if (d == 0) mem_rdata = v;
        else l_mrdata[d-1] = v;
      end
    end
  end

  // Monitor: reference model of grant timing, bus contents, acks and read data.
  initial begin
    forever begin
      @(negedge clk);
      hen[0][cyc % 8] = (mem_en === 1'b1) && (mem_we === 1'b0);
      haddr[0][cyc % 8] = mem_addr;
      for (int d = 0; d < 2; d++) begin
        hen[d+1][cyc % 8] = (l_en[d] === 1'b1);
        haddr[d+1][cyc % 8] = l_maddr[d];
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) mem[mem_addr] = mem_wdata;

      if (rst !== 1'b1) begin
        cq.delete();
        dq.delete();
        g_cyc = -100;
        ack_cyc = cyc;
        last = 1'b1;
        e_addr = '0;
        e_wdata = '0;
        e_rdata[0] = '0;
        e_rdata[1] = '0;
        ack_seen[0] = 0;
        ack_seen[1] = 0;
      end else begin
        logic eca, eda, e_en;
        txn_t t;
        e_en = (cyc == g_cyc + 1);
        eca = (cyc == ack_cyc) && (g_who == 1'b0) && (g_cyc >= 0);
        eda = (cyc == ack_cyc) && (g_who == 1'b1) && (g_cyc >= 0);
        if (eca || eda) begin
          if (g_who == 1'b0 && cq.size() > 0) t = cq.pop_front();
          else if (g_who == 1'b1 && dq.size() > 0) t = dq.pop_front();
          else begin
            t.we = 1'b1;
            chk("scoreboard_empty_at_ack", 0, 1);
          end
          if (!t.we) e_rdata[g_who] = t.rdata;
        end
        chk("mem_en_we", {mem_en, mem_we}, {e_en, e_en & g_we});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("acks", {cpu_ack, dma_ack}, {eca, eda});
        chk("cpu_rdata", cpu_rdata, e_rdata[0]);
        chk("dma_rdata", dma_rdata, e_rdata[1]);
        chk("busy", busy, (cyc > g_cyc) && (cyc <= ack_cyc));
        chk("cpu_stall", cpu_stall, cpu_req & ~eca);
        if (cpu_ack === 1'b1) begin ack_seen[0] = 1; ack_at[0] = cyc; end
        if (dma_ack === 1'b1) begin ack_seen[1] = 1; ack_at[1] = cyc; end

        if (cyc > ack_cyc && (cpu_req || dma_req)) begin
          logic w;
          if (cpu_req && dma_req) begin
`ifdef MEM_ARB_RR_EN
            w = ~last;
`else
            w = 1'b0;
`endif
          end else begin
            w = cpu_req ? 1'b0 : 1'b1;
          end
          last = w;
          if ((w == 1'b0 && cq.size() == 0) || (w == 1'b1 && dq.size() == 0)) begin
            chk("scoreboard_empty_at_grant", 0, 1);
          end else begin
            t = (w == 1'b0) ? cq[0] : dq[0];
            g_who = w;
            g_we = t.we;
            g_cyc = cyc;
            ack_cyc = cyc + (t.we ? 2 : LAT + 2);
            e_addr = t.addr;
            e_wdata = t.wdata;
            granted[w] = 1;
          end
        end
      end
    end
  end

  // One requester transaction; holds req until the cycle after its ack, or drops early once granted.
  task automatic do_txn(input int r, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit early, output int lat);
    txn_t t;
    int   t0, n;
    @(posedge clk);
    #1;
    t.we = we; t.addr = addr; t.wdata = wdata;
    t.rdata = we ? 32'h0 : shadow_rd(addr);
    if (we) shadow[addr] = wdata;
    granted[r] = 0;
    ack_seen[r] = 0;
    if (r == 0) begin
      cq.push_back(t);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      dq.push_back(t);
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end
    t0 = cyc;
    if (early) begin
      n = 0;
      while (!granted[r] && n < 60) begin @(posedge clk); #1; n++; end
      if (!we) begin @(posedge clk); #1; end
      if (r == 0) cpu_req = 1'b0; else dma_req = 1'b0;
    end
    n = 0;
    while (!ack_seen[r] && n < 60) begin @(posedge clk); #1; n++; end
    if (r == 0) cpu_req = 1'b0; else dma_req = 1'b0;
    if (!ack_seen[r]) begin
      chk("ack_timeout", 0, 1);
      lat = -1;
    end else begin
      lat = ack_at[r] - t0;
    end
  endtask

  task automatic run_req(input int r, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = (r == 0 ? 32'h1000 : 32'h2000) + 32'($urandom_range(0, 15)) * 4;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_txn(r, 1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 3) == 0), lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int lat_c, lat_d;
    int got [2];
    logic [31:0] lrd [2];

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_acks", {cpu_ack, dma_ack}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_rdata", {cpu_rdata, dma_rdata}, 0);

    do_txn(0, 1'b0, 32'h100, 32'h5555, 0, lat_c);
    chk("cpu_read_lat", lat_c, LAT + 2);
    chk("cpu_read_data", cpu_rdata, 32'hDEADBEEF);

    do_txn(1, 1'b1, 32'h40, 32'h1234, 0, lat_d);
    chk("dma_write_lat", lat_d, 2);
    chk("dma_write_mem", mem_rd(32'h40), 32'h1234);

    do_txn(0, 1'b0, 32'h180, 32'h0, 1, lat_c);
    chk("abort_read_lat", lat_c, LAT + 2);

    // Reset while a CPU read sits in WAIT: the read must vanish without an ack.
    @(posedge clk);
    #1;
    cq.push_back('{1'b0, 32'h1C0, 32'h0, shadow_rd(32'h1C0)});
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1C0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    ack_seen[0] = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("post_reset_no_ack", ack_seen[0], 0);
    chk("post_reset_mem_en", mem_en, 0);
    chk("post_reset_cpu_rdata", cpu_rdata, 0);
    chk("post_reset_busy", busy, 0);

    fork
      do_txn(0, 1'b0, 32'h10, 32'h0, 0, lat_c);
      do_txn(1, 1'b0, 32'h20, 32'h0, 0, lat_d);
    join
    chk("tie_first_lat", lat_c, LAT + 2);
    chk("tie_second_lat", lat_d, 2 * (LAT + 2) + 1);
    chk("tie_cpu_data", cpu_rdata, init_val(32'h10));
    chk("tie_dma_data", dma_rdata, init_val(32'h20));

    for (int k = 0; k < 3; k++) begin
      fork
        do_txn(0, 1'b0, 32'h10 + 32'(k) * 4, 32'h0, 0, lat_c);
        do_txn(1, 1'b0, 32'h20 + 32'(k) * 4, 32'h0, 0, lat_d);
      join
    end

    fork
      run_req(0, 40);
      run_req(1, 40);
    join

    // Latency of the LAT=1 and LAT=7 instances for a read raised in IDLE.
    @(posedge clk);
    #1;
    l_addr = 32'h300;
    l_req = 2'b11;
    got[0] = -1; got[1] = -1;
    lrd[0] = '0; lrd[1] = '0;
    begin
      int t0;
      t0 = cyc;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        for (int d = 0; d < 2; d++)
          if (l_ack[d] === 1'b1 && got[d] < 0) begin
            got[d] = cyc - t0;
            lrd[d] = l_rdata[d];
          end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) if (got[d] >= 0) l_req[d] = 1'b0;
      end
    end
    chk("lat1_ack", got[0], 3);
    chk("lat7_ack", got[1], 9);
    chk("lat1_data", lrd[0], init_val(32'h300));
    chk("lat7_data", lrd[1], init_val(32'h300));

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
